// File: rtl/dma_reg_slave.sv
// CPU-side register file of an 8237A-style DMA controller: decodes I/O strobes,
// holds command/mode/mask/request/status and per-channel base/current registers.
module dma_reg_slave #(
  parameter int NCH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              ior_n,
  input  logic              iow_n,
  input  logic [3:0]        addr_lo,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              dout_en,
  input  logic [NCH-1:0]    tc,
  input  logic [NCH-1:0]    dreq_pend,
  input  logic              upd_en,
  input  logic [1:0]        upd_ch,
  input  logic [15:0]       upd_addr,
  input  logic [15:0]       upd_cnt,
  output logic [7:0]        cmd_reg,
  output logic [6*NCH-1:0]  mode_reg,
  output logic [NCH-1:0]    mask,
  output logic [NCH-1:0]    sw_req,
  output logic [16*NCH-1:0] cur_addr,
  output logic [16*NCH-1:0] cur_cnt
);

  logic           cs_s, ior_s, iow_s, ior_p, iow_p;
  logic           wr_det, rd_det, chan_acc, mclr, stat_rd;
  logic           ff;
  logic [NCH-1:0] tc_stat;
  logic [15:0]    rd_word;
  logic [7:0]     rd_data;

  // A strobe counts only on its falling edge; both strobes low is ignored.
  assign wr_det   = !cs_s && !iow_s && iow_p && ior_s;
  assign rd_det   = !cs_s && !ior_s && ior_p && iow_s;
  assign chan_acc = !addr_lo[3];
  assign mclr     = wr_det && (addr_lo == 4'hD);
  assign stat_rd  = rd_det && (addr_lo == 4'h8);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [15:0] base_a, base_c, cur_a, cur_c;
      logic [5:0]  mode;
      logic        mask_b, req_b, tc_b;
      logic        wr_a, wr_c, sel_din, auto_init;

      assign wr_a      = wr_det && chan_acc && (addr_lo[2:1] == 2'(gi)) && !addr_lo[0];
      assign wr_c      = wr_det && chan_acc && (addr_lo[2:1] == 2'(gi)) && addr_lo[0];
      assign sel_din   = (din[1:0] == 2'(gi));
      assign auto_init = mode[2];

      // Later assignments override: CPU byte write beats reload, reload beats engine update.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          base_a <= '0;
          base_c <= '0;
          cur_a  <= '0;
          cur_c  <= '0;
        end else begin
          if (tc[gi] && auto_init) begin
            cur_a <= base_a;
            cur_c <= base_c;
          end else if (upd_en && (upd_ch == 2'(gi))) begin
            cur_a <= upd_addr;
            cur_c <= upd_cnt;
          end
          if (wr_a) begin
            if (ff) begin
              base_a[15:8] <= din;
              cur_a[15:8]  <= din;
            end else begin
              base_a[7:0]  <= din;
              cur_a[7:0]   <= din;
            end
          end
          if (wr_c) begin
            if (ff) begin
              base_c[15:8] <= din;
              cur_c[15:8]  <= din;
            end else begin
              base_c[7:0]  <= din;
              cur_c[7:0]   <= din;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mode   <= '0;
          mask_b <= 1'b1;
          req_b  <= 1'b0;
          tc_b   <= 1'b0;
        end else begin
          if (wr_det && (addr_lo == 4'hB) && sel_din)
            mode <= din[7:2];

          if (mclr)
            mask_b <= 1'b1;
          else if (wr_det && (addr_lo == 4'hE))
            mask_b <= 1'b0;
          else if (wr_det && (addr_lo == 4'hF))
            mask_b <= din[gi];
          else if (wr_det && (addr_lo == 4'hA) && sel_din)
            mask_b <= din[2];
          else if (tc[gi] && !auto_init)
            mask_b <= 1'b1;

          if (mclr)
            req_b <= 1'b0;
          else if (wr_det && (addr_lo == 4'h9) && sel_din)
            req_b <= din[2];
          else if (tc[gi])
            req_b <= 1'b0;

          // A new terminal count survives a status read in the same cycle.
          if (mclr)
            tc_b <= 1'b0;
          else if (tc[gi])
            tc_b <= 1'b1;
          else if (stat_rd)
            tc_b <= 1'b0;
        end
      end

      assign cur_addr[16*gi +: 16] = cur_a;
      assign cur_cnt[16*gi +: 16]  = cur_c;
      assign mode_reg[6*gi +: 6]   = mode;
      assign mask[gi]              = mask_b;
      assign sw_req[gi]            = req_b;
      assign tc_stat[gi]           = tc_b;
    end
  endgenerate

  always_comb begin
    rd_word = addr_lo[0] ? cur_cnt[{addr_lo[2:1], 4'b0000} +: 16]
                         : cur_addr[{addr_lo[2:1], 4'b0000} +: 16];
    rd_data = 8'h00;
    if (chan_acc)
      rd_data = ff ? rd_word[15:8] : rd_word[7:0];
    else if (addr_lo == 4'h8)
      rd_data = {dreq_pend, tc_stat};
    // Temporary register (0xD) and all other addresses read as zero.
  end

  // Strobe history resets to "low" so a strobe held through reset is not an access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s    <= 1'b1;
      ior_s   <= 1'b0;
      iow_s   <= 1'b0;
      ior_p   <= 1'b0;
      iow_p   <= 1'b0;
      dout    <= 8'h00;
      dout_en <= 1'b0;
      cmd_reg <= 8'h00;
      ff      <= 1'b0;
    end else begin
      cs_s  <= cs_n;
      ior_s <= ior_n;
      iow_s <= iow_n;
      ior_p <= ior_s;
      iow_p <= iow_s;

      if (rd_det) begin
        dout    <= rd_data;
        dout_en <= 1'b1;
      end else if (ior_s) begin
        dout_en <= 1'b0;
      end

      if ((rd_det || wr_det) && chan_acc)
        ff <= ~ff;

      if (wr_det) begin
        case (addr_lo)
          4'h8: cmd_reg <= din;
          4'hC: ff <= 1'b0;
          4'hD: begin
            cmd_reg <= 8'h00;
            ff      <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_reg_slave.sv
// Directed bench for dma_reg_slave: drives CPU bus cycles and engine events,
// compares outputs against hand-computed values.
module tb_dma_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1, ior_n = 1'b1, iow_n = 1'b1;
  logic [3:0]  addr_lo = 4'h0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        dout_en;
  logic [3:0]  tc = 4'h0, dreq_pend = 4'h0;
  logic        upd_en = 1'b0;
  logic [1:0]  upd_ch = 2'd0;
  logic [15:0] upd_addr = 16'h0, upd_cnt = 16'h0;
  logic [7:0]  cmd_reg;
  logic [23:0] mode_reg;
  logic [3:0]  mask, sw_req;
  logic [63:0] cur_addr, cur_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] rd;
  logic       rd_en;

  dma_reg_slave #(.NCH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .ior_n(ior_n), .iow_n(iow_n),
    .addr_lo(addr_lo), .din(din), .dout(dout), .dout_en(dout_en),
    .tc(tc), .dreq_pend(dreq_pend), .upd_en(upd_en), .upd_ch(upd_ch),
    .upd_addr(upd_addr), .upd_cnt(upd_cnt), .cmd_reg(cmd_reg),
    .mode_reg(mode_reg), .mask(mask), .sw_req(sw_req),
    .cur_addr(cur_addr), .cur_cnt(cur_cnt)
  );

  always #5 clk = ~clk;

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cs_n = 1'b0; addr_lo = a; din = d; iow_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    iow_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("wr addr=%h data=%h", a, d);
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d, output logic en);
    @(posedge clk); #1;
    cs_n = 1'b0; addr_lo = a; ior_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    d = dout; en = dout_en;
    ior_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("rd addr=%h data=%h", a, d);
  endtask

  task automatic pulse_tc(input logic [3:0] t);
    @(posedge clk); #1; tc = t;
    @(posedge clk); #1; tc = 4'h0;
  endtask

  task automatic pulse_upd(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] c);
    @(posedge clk); #1; upd_en = 1'b1; upd_ch = ch; upd_addr = a; upd_cnt = c;
    @(posedge clk); #1; upd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (mask !== 4'hF) begin n_fail++; $display("FAIL reset_mask: got %h want %h", mask, 4'hF); end
    n_cmp++; if ({cmd_reg, sw_req, dout, dout_en} !== 21'h0) begin n_fail++;
      $display("FAIL reset_ctrl: cmd=%h req=%h dout=%h en=%b want all 0", cmd_reg, sw_req, dout, dout_en); end
    n_cmp++; if ({mode_reg, cur_addr, cur_cnt} !== 152'h0) begin n_fail++;
      $display("FAIL reset_regs: mode=%h addr=%h cnt=%h want 0", mode_reg, cur_addr, cur_cnt); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      cpu_read(4'(i), rd, rd_en);
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_read_%0d: got %h want 00", i, rd); end
    end
    n_cmp++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL read_en_high: got %b want 1", rd_en); end
    n_cmp++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL read_en_low: got %b want 0", dout_en); end
  endtask

  task automatic test_ff();
    cpu_write(4'hC, 8'h00);
    cpu_write(4'h2, 8'h34);
    cpu_write(4'h2, 8'h12);
    n_cmp++; if (cur_addr[31:16] !== 16'h1234) begin n_fail++; $display("FAIL ff_write: got %h want 1234", cur_addr[31:16]); end
    cpu_read(4'h2, rd, rd_en);
    n_cmp++; if (rd !== 8'h34) begin n_fail++; $display("FAIL ff_read_lo: got %h want 34", rd); end
    cpu_read(4'h2, rd, rd_en);
    n_cmp++; if (rd !== 8'h12) begin n_fail++; $display("FAIL ff_read_hi: got %h want 12", rd); end
  endtask

  task automatic test_autoinit();
    cpu_write(4'hB, 8'h58);
    n_cmp++; if (mode_reg[5:0] !== 6'h16) begin n_fail++; $display("FAIL mode_ch0: got %h want 16", mode_reg[5:0]); end
    cpu_write(4'h1, 8'h05);
    cpu_write(4'h1, 8'h00);
    cpu_write(4'hE, 8'h00);
    n_cmp++; if (mask !== 4'h0) begin n_fail++; $display("FAIL mask_clear_all: got %h want 0", mask); end
    pulse_upd(2'd0, 16'hBEEF, 16'h0002);
    n_cmp++; if ({cur_addr[15:0], cur_cnt[15:0]} !== 32'hBEEF_0002) begin n_fail++;
      $display("FAIL upd_ch0: got %h want beef0002", {cur_addr[15:0], cur_cnt[15:0]}); end
    pulse_tc(4'b0001);
    n_cmp++; if ({cur_addr[15:0], cur_cnt[15:0]} !== 32'h0000_0005) begin n_fail++;
      $display("FAIL autoinit_reload: got %h want 00000005", {cur_addr[15:0], cur_cnt[15:0]}); end
    n_cmp++; if (mask[0] !== 1'b0) begin n_fail++; $display("FAIL autoinit_mask: got %b want 0", mask[0]); end
    cpu_read(4'h8, rd, rd_en);
    n_cmp++; if (rd !== 8'h01) begin n_fail++; $display("FAIL status_tc0: got %h want 01", rd); end
    cpu_read(4'h8, rd, rd_en);
    n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL status_cleared: got %h want 00", rd); end
    dreq_pend = 4'hA;
    cpu_read(4'h8, rd, rd_en);
    dreq_pend = 4'h0;
    n_cmp++; if (rd !== 8'hA0) begin n_fail++; $display("FAIL status_dreq: got %h want a0", rd); end
  endtask

  task automatic test_noauto();
    cpu_write(4'hB, 8'h02);
    cpu_write(4'h9, 8'h06);
    n_cmp++; if (sw_req !== 4'b0100) begin n_fail++; $display("FAIL sw_req_set: got %b want 0100", sw_req); end
    pulse_tc(4'b0100);
    n_cmp++; if (mask !== 4'b0100) begin n_fail++; $display("FAIL tc_mask_ch2: got %b want 0100", mask); end
    n_cmp++; if (sw_req !== 4'b0000) begin n_fail++; $display("FAIL tc_req_clr: got %b want 0000", sw_req); end
    cpu_read(4'h8, rd, rd_en);
    n_cmp++; if (rd !== 8'h04) begin n_fail++; $display("FAIL status_tc2: got %h want 04", rd); end
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    cs_n = 1'b0; addr_lo = 4'h0; din = 8'hAA; iow_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    iow_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("wr addr=0 data=aa (held 5 cycles)");
    n_cmp++; if (cur_addr[15:0] !== 16'h00AA) begin n_fail++; $display("FAIL hold_write: got %h want 00aa", cur_addr[15:0]); end
    cpu_write(4'h0, 8'h55);
    n_cmp++; if (cur_addr[15:0] !== 16'h55AA) begin n_fail++; $display("FAIL hold_ff_once: got %h want 55aa", cur_addr[15:0]); end
    @(posedge clk); #1;
    cs_n = 1'b0; addr_lo = 4'h0; din = 8'h77; iow_n = 1'b0; ior_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL both_low_en: got %b want 0", dout_en); end
    iow_n = 1'b1; ior_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("both strobes low addr=0 data=77");
    n_cmp++; if (cur_addr[15:0] !== 16'h55AA) begin n_fail++; $display("FAIL both_low_write: got %h want 55aa", cur_addr[15:0]); end
    cpu_read(4'h0, rd, rd_en);
    n_cmp++; if (rd !== 8'hAA) begin n_fail++; $display("FAIL both_low_ff: got %h want aa", rd); end
    cpu_write(4'hC, 8'h00);
  endtask

  task automatic test_simultaneous();
    // Status read with tc[1] arriving on the detection edge
    @(posedge clk); #1; cs_n = 1'b0; addr_lo = 4'h8; ior_n = 1'b0;
    @(posedge clk); #1; tc = 4'b0010;
    @(posedge clk); #1; tc = 4'h0; rd = dout;
    ior_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("rd addr=8 data=%h (with tc1)", rd);
    n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL tc_read_old: got %h want 00", rd); end
    cpu_read(4'h8, rd, rd_en);
    n_cmp++; if (rd !== 8'h02) begin n_fail++; $display("FAIL tc_read_kept: got %h want 02", rd); end
    n_cmp++; if (mask !== 4'b0110) begin n_fail++; $display("FAIL tc_mask_ch1: got %b want 0110", mask); end
    // CPU address write vs engine update on channel 1
    @(posedge clk); #1; cs_n = 1'b0; addr_lo = 4'h2; din = 8'h9C; iow_n = 1'b0;
    @(posedge clk); #1; upd_en = 1'b1; upd_ch = 2'd1; upd_addr = 16'hABCD; upd_cnt = 16'h0001;
    @(posedge clk); #1; upd_en = 1'b0; iow_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("wr addr=2 data=9c (with upd ch1)");
    n_cmp++; if (cur_addr[23:16] !== 8'h9C) begin n_fail++; $display("FAIL cpu_beats_upd: got %h want 9c", cur_addr[23:16]); end
    cpu_write(4'hC, 8'h00);
    // Mask write vs tc[3] mask set
    @(posedge clk); #1; cs_n = 1'b0; addr_lo = 4'hF; din = 8'h00; iow_n = 1'b0;
    @(posedge clk); #1; tc = 4'b1000;
    @(posedge clk); #1; tc = 4'h0; iow_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("wr addr=f data=00 (with tc3)");
    n_cmp++; if (mask !== 4'h0) begin n_fail++; $display("FAIL cpu_beats_tc_mask: got %h want 0", mask); end
    cpu_read(4'h8, rd, rd_en);
    n_cmp++; if (rd !== 8'h08) begin n_fail++; $display("FAIL status_tc3: got %h want 08", rd); end
  endtask

  task automatic test_master_clear();
    cpu_write(4'h8, 8'h04);
    n_cmp++; if (cmd_reg !== 8'h04) begin n_fail++; $display("FAIL cmd_write: got %h want 04", cmd_reg); end
    cpu_write(4'h9, 8'h05);
    cpu_write(4'h6, 8'h11);
    pulse_tc(4'b0100);
    cpu_write(4'hD, 8'h00);
    n_cmp++; if (cmd_reg !== 8'h00) begin n_fail++; $display("FAIL mclr_cmd: got %h want 00", cmd_reg); end
    n_cmp++; if (mask !== 4'hF) begin n_fail++; $display("FAIL mclr_mask: got %h want f", mask); end
    n_cmp++; if (sw_req !== 4'h0) begin n_fail++; $display("FAIL mclr_req: got %h want 0", sw_req); end
    n_cmp++; if (mode_reg !== 24'h000016) begin n_fail++; $display("FAIL mclr_mode_kept: got %h want 000016", mode_reg); end
    n_cmp++; if (cur_addr[63:48] !== 16'h0011) begin n_fail++; $display("FAIL mclr_cur_kept: got %h want 0011", cur_addr[63:48]); end
    cpu_read(4'h8, rd, rd_en);
    n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mclr_status: got %h want 00", rd); end
    cpu_write(4'h6, 8'h22);
    n_cmp++; if (cur_addr[63:48] !== 16'h0022) begin n_fail++; $display("FAIL mclr_ff: got %h want 0022", cur_addr[63:48]); end
    pulse_upd(2'd0, 16'h0000, 16'h0000);
    pulse_tc(4'b0001);
    n_cmp++; if ({cur_addr[15:0], cur_cnt[15:0]} !== 32'h55AA_0005) begin n_fail++;
      $display("FAIL mclr_base_kept: got %h want 55aa0005", {cur_addr[15:0], cur_cnt[15:0]}); end
  endtask

  initial begin
    test_reset();
    test_ff();
    test_autoinit();
    test_noauto();
    test_hold();
    test_simultaneous();
    test_master_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
